// File: rtl/fifo_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// pkg_fifo_arb
//   Shared types and constants for fifo_write_arbiter and its round-robin
//   picker.
//   - fwa_state_t : arbiter FSM state encoding (IDLE, ISSUE, BLOCKED)
//   - ID_W        : width of the requester ID tag in the low bits of each word
//   - OVF_W       : width of the optional blocked-cycle counter
//   - idx_w()     : index width for NREQ requesters (never below 1 bit)
// ----------------------------------------------------------------------------
package pkg_fifo_arb;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      BLOCKED = 2'd2
   } fwa_state_t;

   localparam int ID_W  = 8;
   localparam int OVF_W = 16;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker: selects the first asserted
//   request at or after ptr, wrapping from NREQ-1 back to 0.
//   Ports:
//     req     in   NREQ   request vector
//     ptr     in   IW     starting search position (0..NREQ-1)
//     gnt     out  NREQ   one-hot grant (all zero when no request)
//     gnt_idx out  IW     binary index of the granted requester
// ----------------------------------------------------------------------------
module rr_arbiter
   import pkg_fifo_arb::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx
);

   logic [IW:0]   sum;
   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int off = 0; off < NREQ; off++) begin
         // ptr + off never exceeds 2*NREQ-2, so one conditional subtract wraps it.
         sum = {1'b0, ptr} + (IW+1)'(off);
         if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
         end
         idx = sum[IW-1:0];
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_write_arbiter
//   Shares the single FIFO write port among NREQ requesters with round-robin
//   arbitration. Each granted word is tagged in its low 8 bits with the
//   requester ID and written one clock after the grant.
//   Optional feature macro: FWA_OVF_CNT_EN adds ovf_cnt, a saturating count
//   of clock cycles spent in BLOCKED.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     req_valid    NREQ         requester i has a word
//     req_data     NREQ x PW    payload of requester i
//     req_ready    NREQ         one-hot accept, combinational in grant cycle
//     full_fifo    1            FIFO full flag
//     numel_fifo   clog2(DEPTH) FIFO occupancy
//     wr_en_fifo   1            FIFO write strobe (one cycle per word)
//     wdata_fifo   DWIDTH       {payload, requester ID}; held when idle
//     busy         1            any request pending or write in flight
//     dbg_state    2            current FSM state
//     ovf_cnt      16           blocked-cycle counter (FWA_OVF_CNT_EN only)
//   Handshake: a word moves from requester i when req_valid[i] & req_ready[i]
//   are both high in the same cycle; req_ready never rises without
//   req_valid, and a requester may withdraw req_valid at any time.
// ----------------------------------------------------------------------------
module fifo_write_arbiter
   import pkg_fifo_arb::*;
#(
   parameter  int NREQ   = 4,
   parameter  int DWIDTH = 136,
   parameter  int DEPTH  = 16,
   localparam int PW     = DWIDTH - ID_W,
   localparam int IW     = idx_w(NREQ),
   localparam int NW     = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0][PW-1:0]  req_data,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     full_fifo,
   input  logic [NW-1:0]            numel_fifo,
   output logic                     wr_en_fifo,
   output logic [DWIDTH-1:0]        wdata_fifo,
   output logic                     busy,
   output fwa_state_t               dbg_state
`ifdef FWA_OVF_CNT_EN
   ,
   output logic [OVF_W-1:0]         ovf_cnt
`endif
);

   if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("fifo_write_arbiter: NREQ must be in 2..8");
   end

   fwa_state_t        state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic              wr_en_q, wr_en_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;

   logic [NREQ-1:0]   gnt;
   logic [IW-1:0]     gnt_idx;
   logic              any_req;
   logic              space;
   logic              grant;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // A write already on the port will take the last free slot, so a grant
   // now would land on a full FIFO next cycle.
   assign space   = !full_fifo && !(wr_en_q && numel_fifo == NW'(DEPTH - 1));
   assign any_req = |req_valid;
   // rst_n gates the combinational outputs so they read 0 throughout reset.
   assign grant   = rst_n && space && any_req;

   always_comb begin
      ptr_d   = ptr_q;
      wdata_d = wdata_q;
      wr_en_d = grant;
      if (grant) begin
         wdata_d = {req_data[gnt_idx], ID_W'(gnt_idx)};
         ptr_d   = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, ISSUE: begin
            if (grant)        state_d = ISSUE;
            else if (any_req) state_d = BLOCKED;
            else              state_d = IDLE;
         end
         BLOCKED: begin
            if (grant)         state_d = ISSUE;
            else if (!any_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         wr_en_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         wr_en_q <= wr_en_d;
         wdata_q <= wdata_d;
      end
   end

   assign req_ready  = grant ? gnt : '0;
   assign wr_en_fifo = wr_en_q;
   assign wdata_fifo = wdata_q;
   assign busy       = rst_n && (any_req || wr_en_q);
   assign dbg_state  = state_q;

`ifdef FWA_OVF_CNT_EN
   logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (state_q == BLOCKED && ovf_cnt_q != '1) begin
         ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_cnt_q <= '0;
      else        ovf_cnt_q <= ovf_cnt_d;
   end

   assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//   Drives fifo_write_arbiter against a queue-based model of the downstream
//   FIFO and a round-robin reference: each cycle the expected grant is the
//   first valid requester at or after the last grant + 1, provided the FIFO
//   will still have room once the in-flight write lands.
// ----------------------------------------------------------------------------
module tb_fifo_write_arbiter;
   import pkg_fifo_arb::*;

   localparam int NREQ   = 4;
   localparam int DWIDTH = 136;
   localparam int DEPTH  = 16;
   localparam int PW     = DWIDTH - ID_W;
   localparam int NW     = $clog2(DEPTH);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0]         req_valid = '0;
   logic [NREQ-1:0][PW-1:0] req_data  = '0;
   logic [NREQ-1:0]         req_ready;
   logic                    full_fifo = 1'b0;
   logic [NW-1:0]           numel_fifo = '0;
   logic                    wr_en_fifo;
   logic [DWIDTH-1:0]       wdata_fifo;
   logic                    busy;
   fwa_state_t              dbg_state;
`ifdef FWA_OVF_CNT_EN
   logic [OVF_W-1:0]        ovf_cnt;
`endif

   fifo_write_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .full_fifo  (full_fifo),
      .numel_fifo (numel_fifo),
      .wr_en_fifo (wr_en_fifo),
      .wdata_fifo (wdata_fifo),
      .busy       (busy),
      .dbg_state  (dbg_state)
`ifdef FWA_OVF_CNT_EN
      ,
      .ovf_cnt    (ovf_cnt)
`endif
   );

   // ---------------- scoreboard / model state ----------------
   int n_cmp = 0;
   int n_fail = 0;

   logic [DWIDTH-1:0] exp_q[$];   // model FIFO contents
   logic [DWIDTH-1:0] dut_q[$];   // words the DUT actually wrote
   bit                m_pend;     // model: write on the port this cycle
   logic [DWIDTH-1:0] m_word;
   int                m_ptr;
   fwa_state_t        m_state;
   int                m_blk;
   int                last_gnt;
   bit                d_wr;
   logic [DWIDTH-1:0] d_word;
   int                wr_seen;
   int                run_len;
   int                max_run;

   task automatic chk(input string tag, input logic [DWIDTH-1:0] obs,
                      input logic [DWIDTH-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (p + k) % NREQ;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [PW-1:0] rnd_pw();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic model_reset();
      exp_q.delete();
      dut_q.delete();
      m_pend   = 1'b0;
      m_word   = '0;
      m_ptr    = 0;
      m_state  = IDLE;
      m_blk    = 0;
      last_gnt = -1;
      d_wr     = 1'b0;
      d_word   = '0;
      run_len  = 0;
   endtask

   // ---------------- driver: one clock of stimulus + checks ----------------
   // Entered shortly after a rising edge with req_* already set for the cycle.
   task automatic cycle(input bit pop);
      int                g;
      bit                space;
      logic [NREQ-1:0]   exp_rdy;
      logic [DWIDTH-1:0] w_exp;
      logic [DWIDTH-1:0] w_dut;
      full_fifo  = (dut_q.size() >= DEPTH);
      numel_fifo = NW'(dut_q.size() % DEPTH);
      #1;
      space = (exp_q.size() < DEPTH) && !(m_pend && exp_q.size() == DEPTH - 1);
      g = space ? pick(req_valid, m_ptr) : -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g[1:0]] = 1'b1;
      chk("req_ready", DWIDTH'(req_ready), DWIDTH'(exp_rdy));
      chk("busy", DWIDTH'(busy), DWIDTH'((|req_valid) || m_pend));
      @(posedge clk);
      // FIFO side of the edge
      if (d_wr) begin
         chk("no_overflow", DWIDTH'(dut_q.size() < DEPTH), DWIDTH'(1));
         dut_q.push_back(d_word);
      end
      if (m_pend) exp_q.push_back(m_word);
      if (pop && exp_q.size() > 0) begin
         w_exp = exp_q.pop_front();
         w_dut = (dut_q.size() > 0) ? dut_q.pop_front() : 'x;
         chk("read_back", w_dut, w_exp);
      end
      // arbiter side of the edge
      if (m_state == BLOCKED) m_blk++;
      m_state = (g >= 0) ? ISSUE : ((|req_valid) ? BLOCKED : IDLE);
      m_pend  = (g >= 0);
      if (g >= 0) begin
         m_word = {req_data[g[1:0]], 8'(g)};
         m_ptr  = (g + 1) % NREQ;
      end
      last_gnt = g;
      #1;
      d_wr   = wr_en_fifo;
      d_word = wdata_fifo;
      chk("wr_en", DWIDTH'(wr_en_fifo), DWIDTH'(m_pend));
      chk("wdata", wdata_fifo, m_word);
      chk("state", DWIDTH'(dbg_state), DWIDTH'(m_state));
`ifdef FWA_OVF_CNT_EN
      chk("ovf_cnt", DWIDTH'(ovf_cnt), DWIDTH'((m_blk > 65535) ? 65535 : m_blk));
`endif
      if (d_wr) begin
         wr_seen++;
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end else begin
         run_len = 0;
      end
   endtask

   task automatic upd_reqs(input int p_on);
      for (int i = 0; i < NREQ; i++) begin
         if (last_gnt == i) req_data[i] = rnd_pw();
         if ($urandom_range(99) < p_on) req_valid[i] = 1'b1;
         else if ($urandom_range(99) < 20) req_valid[i] = 1'b0;
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int wr_before;
      model_reset();
      wr_seen = 0;
      max_run = 0;

      // reset state with requests already asserted
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) req_data[i] = rnd_pw();
      #12;
      chk("rst_wr_en", DWIDTH'(wr_en_fifo), '0);
      chk("rst_req_ready", DWIDTH'(req_ready), '0);
      chk("rst_busy", DWIDTH'(busy), '0);
      chk("rst_wdata", wdata_fifo, '0);
      chk("rst_state", DWIDTH'(dbg_state), DWIDTH'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;

      // fairness and fill: all requesters held, FIFO empty
      for (int c = 0; c < 22; c++) begin
         if (c > 0 && d_wr) chk("id_order", DWIDTH'(d_word[7:0]), DWIDTH'((wr_seen - 1) % NREQ));
         cycle(1'b0);
         if (last_gnt >= 0) req_data[last_gnt[1:0]] = rnd_pw();
      end
      chk("fill_writes", DWIDTH'(wr_seen), DWIDTH'(DEPTH));
      chk("fill_run", DWIDTH'(max_run), DWIDTH'(DEPTH));
      chk("full_ready", DWIDTH'(req_ready), '0);
      chk("full_state", DWIDTH'(dbg_state), DWIDTH'(BLOCKED));

      // drain one word: exactly one new write follows
      wr_before = wr_seen;
      cycle(1'b1);
      cycle(1'b0);
      cycle(1'b0);
      chk("resume_2clk", DWIDTH'(wr_seen - wr_before), DWIDTH'(1));
      for (int c = 0; c < 4; c++) cycle(1'b0);
      chk("resume_once", DWIDTH'(wr_seen - wr_before), DWIDTH'(1));

      // park the pointer on requester 3, then reset mid-write
      req_valid = 4'b0100;
      for (int c = 0; c < 4; c++) begin
         cycle(1'b1);
         if (last_gnt == 2) break;
      end
      chk("park_write", DWIDTH'(wr_en_fifo), DWIDTH'(1));
      req_valid = '1;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_wr_en", DWIDTH'(wr_en_fifo), '0);
      chk("midrst_req_ready", DWIDTH'(req_ready), '0);
      chk("midrst_busy", DWIDTH'(busy), '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b0);
      chk("post_rst_id", DWIDTH'(d_word[7:0]), DWIDTH'(0));

      // randomized traffic with random drains and withdrawals
      for (int c = 0; c < 400; c++) begin
         upd_reqs(40);
         cycle($urandom_range(99) < 55);
      end

      // empty the FIFO, then a lone requester is granted every cycle
      req_valid = '0;
      for (int c = 0; c < DEPTH + 4; c++) cycle(1'b1);
      req_valid = 4'b1000;
      wr_before = wr_seen;
      for (int c = 0; c < 10; c++) begin
         cycle(1'b0);
         if (last_gnt >= 0) req_data[3] = rnd_pw();
      end
      chk("single_req", DWIDTH'(wr_seen - wr_before), DWIDTH'(10));
      req_valid = '0;
      for (int c = 0; c < DEPTH + 4; c++) cycle(1'b1);

`ifdef FWA_OVF_CNT_EN
      // blocked-cycle counter: 100 cycles, then saturation
      req_valid = '1;
      for (int c = 0; c < DEPTH + 2; c++) cycle(1'b0);
      wr_before = int'(ovf_cnt);
      for (int c = 0; c < 100; c++) cycle(1'b0);
      chk("ovf_100", DWIDTH'(int'(ovf_cnt) - wr_before), DWIDTH'(100));
      for (int c = 0; c < 70000; c++) cycle(1'b0);
      chk("ovf_sat", DWIDTH'(ovf_cnt), DWIDTH'(16'hFFFF));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
